// File: rtl/srt_quot_unpack.sv
// srt_quot_unpack: serial MSB-first radix-4 signed-digit to binary quotient converter (optional SRT_SIGN_CORR_EN sign correction)
module srt_quot_unpack #(
  parameter int VEC_W = 71,
  parameter int NDIGITS = 23,
  parameter int Q_W = 2*NDIGITS+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VEC_W-1:0] data_in,
`ifdef SRT_SIGN_CORR_EN
  input  logic             rem_neg,
`endif
  output logic             busy,
  output logic [2:0]       digit_out,
  output logic             digit_valid,
  output logic [Q_W-1:0]   q_out,
  output logic             done,
  output logic             err
);
  localparam int CW = $clog2(NDIGITS+1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [3*NDIGITS-1:0] shreg;
  logic [Q_W-1:0] acc, acc_n, dext, q_fin;
  logic [CW-1:0] cnt;
  logic [2:0] d;
  logic illegal, accept, last, corr;
  logic unused_bits;
  assign unused_bits = ^data_in;
  assign d = shreg[3*NDIGITS-1 -: 3];
  assign illegal = (d == 3'b011) || (d == 3'b100);
  assign dext = illegal ? '0 : {{(Q_W-3){d[2]}}, d};
  assign acc_n = (acc << 2) + dext;
  assign accept = (state == IDLE) && start;
  assign last = (state == RUN) && (cnt == CW'(1));
  assign q_fin = corr ? acc_n - Q_W'(1) : acc_n;
  assign busy = state != IDLE;
  assign digit_valid = state == RUN;
  assign digit_out = digit_valid ? d : 3'b000;
  assign done = state == DONE;
  // next-state decode
  always_comb begin
    state_n = accept ? RUN : last ? DONE : (state == DONE) ? IDLE : state;
  end
  // state, datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      acc <= '0;
      cnt <= '0;
      q_out <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        shreg <= data_in[3*NDIGITS-1:0];
        acc <= '0;
        cnt <= CW'(NDIGITS);
        err <= 1'b0;
      end else if (state == RUN) begin
        shreg <= shreg << 3;
        acc <= acc_n;
        cnt <= cnt - CW'(1);
        err <= err | illegal;
        if (last) q_out <= q_fin;
      end
    end
  end
`ifdef SRT_SIGN_CORR_EN
  logic rem_neg_q;
  assign corr = rem_neg_q;
  // remainder sign captured alongside the digit vector
  always_ff @(posedge clk) begin
    if (reset) rem_neg_q <= 1'b0;
    else if (accept) rem_neg_q <= rem_neg;
  end
`else
  assign corr = 1'b0;
`endif
endmodule

// File: tb/tb_srt_quot_unpack.sv
// tb_srt_quot_unpack: directed self-checking bench with NDIGITS=4
module tb_srt_quot_unpack;
  logic clk = 1'b0;
  logic reset, start, rem_neg;
  logic [15:0] data_in;
  logic busy, digit_valid, done, err;
  logic [2:0] digit_out;
  logic [8:0] q_out;
  int tests = 0;
  int fails = 0;

  srt_quot_unpack #(.VEC_W(16), .NDIGITS(4), .Q_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
`ifdef SRT_SIGN_CORR_EN
    .rem_neg(rem_neg),
`endif
    .busy(busy), .digit_out(digit_out), .digit_valid(digit_valid),
    .q_out(q_out), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 16'(busy), 16'd0);
    check({tag, " done"}, 16'(done), 16'd0);
    check({tag, " digit_valid"}, 16'(digit_valid), 16'd0);
    check({tag, " digit_out"}, 16'(digit_out), 16'd0);
    check({tag, " q_out"}, 16'(q_out), 16'd0);
    check({tag, " err"}, 16'(err), 16'd0);
  endtask

  task automatic run(input string tag, input logic [15:0] d, input logic rn,
                     input logic [11:0] digs, input logic [8:0] eq, input logic ee);
    start = 1'b1;
    data_in = d;
    rem_neg = rn;
    step();
    start = 1'b0;
    data_in = 16'hFFFF;
    rem_neg = ~rn;
    for (int i = 0; i < 4; i++) begin
      check({tag, " digit_valid"}, 16'(digit_valid), 16'd1);
      check({tag, " digit_out"}, 16'(digit_out), 16'(digs[11-3*i -: 3]));
      check({tag, " busy"}, 16'(busy), 16'd1);
      check({tag, " no early done"}, 16'(done), 16'd0);
      step();
    end
    check({tag, " done"}, 16'(done), 16'd1);
    check({tag, " busy in done"}, 16'(busy), 16'd1);
    check({tag, " q_out"}, 16'(q_out), 16'(eq));
    check({tag, " err"}, 16'(err), 16'(ee));
    step();
    check({tag, " done pulse"}, 16'(done), 16'd0);
    check({tag, " idle busy"}, 16'(busy), 16'd0);
    check({tag, " q_out held"}, 16'(q_out), 16'(eq));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rem_neg = 1'b0;
    data_in = 16'h0;
    step();
    step();
    check_idle_zero("reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle busy", 16'(busy), 16'd0);
      check("idle done", 16'(done), 16'd0);
    end
    run("basic", 16'hF382, 1'b0, 12'h382, 9'd34, 1'b0);
    run("all+2", 16'h0492, 1'b0, 12'h492, 9'd170, 1'b0);
    run("all-2", 16'hADB6, 1'b0, 12'hDB6, 9'h156, 1'b0);
    run("illegal", 16'h0302, 1'b0, 12'h302, 9'd66, 1'b1);
    run("err clear", 16'h0382, 1'b0, 12'h382, 9'd34, 1'b0);
    start = 1'b1;
    data_in = 16'h0382;
    step();
    start = 1'b0;
    data_in = 16'h0;
    step();
    start = 1'b1;
    data_in = 16'h0492;
    step();
    start = 1'b0;
    step();
    step();
    check("ignore start done", 16'(done), 16'd1);
    check("ignore start q_out", 16'(q_out), 16'd34);
    step();
    start = 1'b1;
    data_in = 16'h0492;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle_zero("mid-run reset");
    run("after reset", 16'h0382, 1'b0, 12'h382, 9'd34, 1'b0);
`ifdef SRT_SIGN_CORR_EN
    run("corr neg", 16'h0382, 1'b1, 12'h382, 9'd33, 1'b0);
    run("corr pos", 16'h0382, 1'b0, 12'h382, 9'd34, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/srt_quot_unpack.md
Name: srt_quot_unpack

Overview:
- Reader for the packed radix-4 quotient digit vector that the divider's digit shift register accumulates.
- Captures the parallel vector on a start pulse and walks the signed digits MSB-first, one digit per cycle. The MSB digit is the earliest digit shifted in.
- Converts the redundant digit string to a two's-complement binary quotient using acc = 4*acc + d.
- Also exposes each digit serially for debug and scoreboarding. Sits between the divider core's digit register and the result bus.

Parameters:
- VEC_W, 71, width of the packed input vector.
- NDIGITS, 23, number of 3-bit digits consumed from data_in[3*NDIGITS-1:0]; bits above are ignored. Constraint: 3*NDIGITS <= VEC_W.
- Q_W, 2*NDIGITS+1, signed quotient width. This covers the full range ±2*(4^NDIGITS-1)/3.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- data_in  in  VEC_W  packed digits; digit k (k=0 is least significant) occupies data_in[3k+2:3k]; valid in the start cycle
- busy  out  1  high while in RUN or DONE
- digit_out  out  3  digit being processed this cycle
- digit_valid  out  1  high in each RUN cycle
- q_out  out  Q_W  signed binary quotient; held stable from DONE until the next accepted start
- done  out  1  one-cycle pulse, concurrent with the final q_out
- err  out  1  sticky illegal-digit flag; cleared on an accepted start

Behaviour:
- Digit encoding is 3-bit two's complement. Legal values are -2..+2: 110, 111, 000, 001, 010.
  - 011 and 100 are illegal. An illegal digit sets err and contributes 0 to the accumulator.
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE, busy=0, done=0, digit_valid=0, digit_out=0, q_out=0, err=0.
  - Internal shift register, accumulator and counter are cleared.
  - Asserting reset mid-RUN aborts the conversion, and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load shreg <= data_in[3*NDIGITS-1:0], acc <= 0, cnt <= NDIGITS, err <= 0.
  - Then go to RUN.
  - If sampled, rem_neg (optional feature) is captured on the same edge.
- RUN (exactly NDIGITS cycles):
  - digit_out = shreg[3*NDIGITS-1 -: 3], digit_valid=1.
  - acc <= (acc<<2) + sign_extend(digit), with illegal digits treated as 0.
  - shreg <= shreg<<3, cnt <= cnt-1.
  - When cnt==1 on this edge, go to DONE.
- DONE (1 cycle):
  - done=1 and q_out = final acc (after optional correction); q_out is registered on entry to DONE.
  - Then go to IDLE.
- Latency: start sampled at edge 0; done is high during cycle NDIGITS+1. Throughput is one conversion per NDIGITS+2 cycles.
- start in RUN or DONE is ignored and not queued. The data_in change is not seen.
- start in the same cycle the FSM returns to IDLE (i.e. the first IDLE cycle) is accepted normally.
- Accumulator arithmetic is Q_W-bit signed. It cannot overflow for legal digits by construction, and wrap-around is not checked.
- NDIGITS=1 is legal: a single RUN cycle.

Optional Feature:
- Macro: SRT_SIGN_CORR_EN
- With it defined:
  - Extra input rem_neg (in, 1) indicates a negative final partial remainder. It is sampled with an accepted start.
  - When rem_neg is set, q_out = acc - 1 in DONE; this is the standard SRT quotient correction.
- Without it: no rem_neg port, and q_out = acc unmodified.

Test Plan:
- Reset then idle: with reset=1 for 2 cycles, all outputs are 0; after reset deassertion with start=0 for 10 cycles, busy stays 0 and done stays 0.
- NDIGITS=4, digits MSB-first {+1,-2,0,+2} (data_in[11:0]=001_110_000_010): q_out=34 and done in cycle 5. Across cycles 1-4, digit_out sequence is 001,110,000,010 with digit_valid=1; err=0.
- NDIGITS=4, extremes: all 010 -> q_out=170; all 110 -> q_out=-170 (9-bit 0x156).
- Illegal digit: NDIGITS=4, digits {+1,100,0,+2} -> err=1 and q_out=66. The next start with legal data clears err to 0.
- Busy and reset mid-run:
  - A start pulse in RUN cycle 2 with different data is ignored, and the original result 34 is produced.
  - reset asserted in RUN cycle 2 gives no done pulse and all outputs 0. A start in the next cycle then converts correctly.
- With SRT_SIGN_CORR_EN defined: digits {+1,-2,0,+2} with rem_neg=1 -> q_out=33; with rem_neg=0 -> q_out=34.
